// File: rtl/n64_pkg.sv
// Shared definitions for the N64 controller report path: frame layout,
// button indices and link-state encoding.
package n64_pkg;
  localparam int FRAME_BITS = 33;

  localparam int BTN_A     = 0;
  localparam int BTN_B     = 1;
  localparam int BTN_Z     = 2;
  localparam int BTN_START = 3;
  localparam int BTN_DU    = 4;
  localparam int BTN_DD    = 5;
  localparam int BTN_DL    = 6;
  localparam int BTN_DR    = 7;
  localparam int BTN_RST   = 8;
  localparam int BTN_RSVD  = 9;
  localparam int BTN_L     = 10;
  localparam int BTN_R     = 11;
  localparam int BTN_CU    = 12;
  localparam int BTN_CD    = 13;
  localparam int BTN_CL    = 14;
  localparam int BTN_CR    = 15;

  localparam int X_MSB    = 16;
  localparam int Y_MSB    = 24;
  localparam int STOP_BIT = 32;
  localparam int RSVD_BIT = 9;

  typedef enum logic [1:0] {
    NO_LINK = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } link_state_e;

  // Axis fields arrive MSB first, so the lowest frame index is the sign bit.
  function automatic logic [7:0] frame_axis(input logic [FRAME_BITS-1:0] f, input int msb);
    logic [7:0] a;
    for (int i = 0; i < 8; i++) a[7-i] = f[msb+i];
    return a;
  endfunction
endpackage

// File: rtl/n64_axis_deadzone.sv
// Combinational deadzone for one signed 8-bit joystick axis.
module n64_axis_deadzone #(
  parameter int DEADZONE = 8
) (
  input  logic [7:0] axis_i,
  output logic [7:0] axis_o
);
  localparam logic [8:0] DZ = 9'(DEADZONE);

  logic [8:0] ext, mag;

  // Nine bits so that -128 has a representable magnitude of 128.
  always_comb begin
    ext    = {axis_i[7], axis_i};
    mag    = ext[8] ? (9'd0 - ext) : ext;
    axis_o = (mag <= DZ) ? 8'd0 : axis_i;
  end
endmodule

// File: rtl/n64_report_decoder.sv
// Validates, debounces and decodes N64 status frames into committed
// button/axis state with edge pulses and a link-health timeout.
module n64_report_decoder
  import n64_pkg::*;
#(
  parameter int TICKS_PER_MICRO = 25,
  parameter int STABLE_FRAMES   = 2,
  parameter int DEADZONE        = 8,
  parameter int TIMEOUT_US      = 5000
) (
  input  logic                  PCLK,
  input  logic                  RST,
  input  logic [FRAME_BITS-1:0] frame_data,
  input  logic                  frame_valid,
  output logic [15:0]           buttons,
  output logic [7:0]            stick_x,
  output logic [7:0]            stick_y,
  output logic [15:0]           pressed,
  output logic [15:0]           released,
  output logic                  update,
  output logic                  link_ok,
  output logic [7:0]            frame_err_count
);
  localparam logic [31:0] TLIM = 32'(TIMEOUT_US * TICKS_PER_MICRO);
  localparam logic [3:0]  SF   = 4'(STABLE_FRAMES);

  link_state_e           state_q, state_d;
  logic [FRAME_BITS-1:0] cand_q, cand_d;
  logic [3:0]            match_q, match_d;
  logic [31:0]           tcnt_q, tcnt_d;
  logic [15:0]           btn_q, btn_d, pressed_q, pressed_d, released_q, released_d;
  logic [7:0]            x_q, x_d, y_q, y_d, err_q, err_d;
  logic                  upd_q, upd_d;

  logic       good, bad, expire;
  logic [7:0] raw_x, raw_y, dz_x, dz_y;

  assign raw_x = frame_axis(frame_data, X_MSB);
  assign raw_y = frame_axis(frame_data, Y_MSB);

  n64_axis_deadzone #(.DEADZONE(DEADZONE)) u_dz_x (.axis_i(raw_x), .axis_o(dz_x));
  n64_axis_deadzone #(.DEADZONE(DEADZONE)) u_dz_y (.axis_i(raw_y), .axis_o(dz_y));

  assign good   = frame_valid && frame_data[STOP_BIT] && !frame_data[RSVD_BIT];
  assign bad    = frame_valid && !good;
  // A good frame in the expiry cycle pre-empts the timeout.
  assign expire = (state_q != NO_LINK) && !good && (tcnt_q == TLIM - 32'd1);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    tcnt_d  = tcnt_q;
    btn_d   = btn_q;
    x_d     = x_q;
    y_d     = y_q;
    err_d   = err_q;
    if (bad && err_q != 8'hFF) err_d = err_q + 8'd1;
    if (good) begin
      tcnt_d = '0;
      if (frame_data == cand_q) begin
        if (match_q != SF) match_d = match_q + 4'd1;
      end else begin
        cand_d  = frame_data;
        match_d = 4'd1;
      end
      // On commit the candidate equals the incoming frame, so decode it directly.
      if (match_d == SF) begin
        btn_d   = frame_data[15:0];
        x_d     = dz_x;
        y_d     = dz_y;
        state_d = LOCKED;
      end else if (state_q == NO_LINK) begin
        state_d = ACQUIRE;
      end
    end else if (expire) begin
      tcnt_d  = TLIM;
      state_d = NO_LINK;
      btn_d   = '0;
      x_d     = '0;
      y_d     = '0;
      cand_d  = '0;
      match_d = '0;
    end else if (state_q != NO_LINK) begin
      tcnt_d = tcnt_q + 32'd1;
    end
    pressed_d  = btn_d & ~btn_q;
    released_d = btn_q & ~btn_d;
    upd_d      = (btn_d != btn_q) || (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge PCLK or posedge RST) begin
    if (RST) begin
      state_q    <= NO_LINK;
      cand_q     <= '0;
      match_q    <= '0;
      tcnt_q     <= '0;
      btn_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      err_q      <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      match_q    <= match_d;
      tcnt_q     <= tcnt_d;
      btn_q      <= btn_d;
      x_q        <= x_d;
      y_q        <= y_d;
      err_q      <= err_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      upd_q      <= upd_d;
    end
  end

  assign buttons         = btn_q;
  assign stick_x         = x_q;
  assign stick_y         = y_q;
  assign pressed         = pressed_q;
  assign released        = released_q;
  assign update          = upd_q;
  assign link_ok         = (state_q == LOCKED);
  assign frame_err_count = err_q;
endmodule
